// File: rtl/fetch_queue.sv
// fetch_queue: owns the PC, fetches words over imem req/ack into a prefetch FIFO,
// and presents {instruction, PC+4} to decode, honouring stalls and redirects.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc4
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
   state_t state;
   logic [31:0] pc, drop_addr;
   logic [AW-1:0] rd, wr;
   logic [AW:0] count, count_pop;
   logic [31:0] instr_mem [DEPTH];
   logic [31:0] pc4_mem [DEPTH];
   logic pop, push;
   assign if_valid  = count != '0;
   assign pop       = if_valid & ~stall & ~redirect;
   assign push      = (state == REQ) & imem_ack & ~redirect;
   assign count_pop = count - (AW+1)'(pop);
   assign imem_req  = state != IDLE;
   // a dropped fetch keeps presenting its original address until the memory answers
   assign imem_addr = (state == DROP) ? drop_addr : pc;
   assign if_instr  = if_valid ? instr_mem[rd] : '0;
   assign if_pc4    = if_valid ? pc4_mem[rd] : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         drop_addr <= RESET_PC;
         count     <= '0;
         rd        <= '0;
         wr        <= '0;
      end else begin
         if (redirect) begin
            pc    <= redirect_pc & 32'hFFFF_FFFC;
            count <= '0;
            rd    <= '0;
            wr    <= '0;
         end else begin
            count <= count_pop + (AW+1)'(push);
            if (pop) rd <= rd + 1'b1;
            if (push) begin
               instr_mem[wr] <= imem_rdata;
               pc4_mem[wr]   <= pc + 32'd4;
               wr            <= wr + 1'b1;
               pc            <= pc + 32'd4;
            end
         end
         case (state)
            IDLE: if (!redirect && count_pop < FULL) state <= REQ;
            REQ: begin
               if (redirect) begin
                  state <= imem_ack ? IDLE : DROP;
                  if (!imem_ack) drop_addr <= pc;
               end else if (imem_ack) begin
                  state <= (count_pop + 1'b1 < FULL) ? REQ : IDLE;
               end
            end
            DROP: if (imem_ack) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus against a queue-based reference model.
module tb_fetch_queue;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic imem_ack = 1'b0, redirect = 1'b0, stall = 1'b0;
   logic [31:0] imem_rdata = '0, redirect_pc = '0;
   logic imem_req, if_valid, w_req, w_valid;
   logic [31:0] imem_addr, if_instr, if_pc4, w_addr, w_instr, w_pc4;
   int n_chk = 0, n_fail = 0;
   typedef struct packed { logic [31:0] instr; logic [31:0] pc4; } ent_t;
   ent_t q[$];
   int mode = 0;
   logic [31:0] m_pc = '0, m_old = '0;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
      .redirect_pc(redirect_pc), .stall(stall), .if_valid(if_valid),
      .if_instr(if_instr), .if_pc4(if_pc4));

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
      .redirect_pc(redirect_pc), .stall(stall), .if_valid(w_valid),
      .if_instr(w_instr), .if_pc4(w_pc4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare against the model, then advance the model by the rules for the upcoming edge.
   task automatic step();
      bit popv;
      #1;
      chk("imem_req", 32'(imem_req), 32'(mode != 0));
      chk("imem_addr", imem_addr, mode == 2 ? m_old : m_pc);
      chk("if_valid", 32'(if_valid), 32'(q.size() > 0));
      chk("if_instr", if_instr, q.size() > 0 ? q[0].instr : 32'h0);
      chk("if_pc4", if_pc4, q.size() > 0 ? q[0].pc4 : 32'h0);
      popv = q.size() > 0 && !stall && !redirect;
      if (rst) begin
         mode = 0; q.delete(); m_pc = 32'h0;
      end else if (redirect) begin
         if (mode == 1 && !imem_ack) begin m_old = m_pc; mode = 2; end
         else if (mode != 0 && imem_ack) mode = 0;
         q.delete();
         m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
         if (popv) void'(q.pop_front());
         if (mode == 0) begin
            if (q.size() < DEPTH) mode = 1;
         end else if (mode == 1) begin
            if (imem_ack) begin
               q.push_back('{instr: imem_rdata, pc4: m_pc + 32'd4});
               m_pc = m_pc + 32'd4;
               if (q.size() == DEPTH) mode = 0;
            end
         end else if (imem_ack) mode = 0;
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic a, input logic s, input logic r, input logic [31:0] rp);
      imem_ack = a; stall = s; redirect = r; redirect_pc = rp; imem_rdata = $urandom;
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; stall = 1'b0;
      @(negedge clk); @(negedge clk);
      mode = 0; q.delete(); m_pc = 32'h0;
      rst = 1'b0;
   endtask

   initial begin
      // zero-wait memory, no stall; wrap instance checked in lockstep
      do_reset();
      chk("wrap_rst_req", 32'(w_req), 32'h0);
      chk("wrap_rst_addr", w_addr, 32'hFFFF_FFF8);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk("wrap_req1", w_addr, 32'hFFFF_FFF8);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      chk("wrap_addr2", w_addr, 32'hFFFF_FFFC);
      chk("wrap_pc4_a", w_pc4, 32'hFFFF_FFFC);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      chk("wrap_addr3", w_addr, 32'h0000_0000);
      chk("wrap_pc4_b", w_pc4, 32'h0000_0000);
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 32'h0);
      // stall saturates the queue, then drains in order
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, 32'h0);
      // 3-cycle memory, redirect on the 2nd wait cycle of a fetch
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 1'b1, 32'h100);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 32'h0);
      // redirect coincident with ack and pop at count=2
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b1, 32'h103);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 32'h0);
      // reset mid-REQ with an ack in the same cycle, then a stale ack
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      rst = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 32'h0);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 15) == 0, $urandom);
      end
      rst = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
